// File: rtl/uart_alu_responder.sv
// uart_alu_responder
//   Byte-stream command responder that sits between a UART receiver and a
//   UART transmitter. Packet layout: opcode, reserved, LEN lo, LEN hi,
//   then payload. LEN counts the whole packet, including the 4 header bytes.
//   ECHO  : every payload byte is returned through a one-byte buffer.
//   ADD32 : the payload is summed as little-endian 32-bit words, and the
//           result is sent LSB first.
//   Other : the payload is consumed silently.
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   rx_data_i/valid_i      byte stream in; rx_ready_o is the accept strobe
//   tx_data_o/valid_o      byte stream out; tx_ready_i is the sink accept
//   busy_o                 high whenever a packet is in progress
//
// state      | meaning
// ST_OPCODE  | idle, waiting for the opcode byte
// ST_RSVD    | discarding the reserved byte
// ST_LEN_LO  | capturing LEN[7:0]
// ST_LEN_HI  | capturing LEN[15:8] and loading the remaining-byte counter
// ST_PAYLOAD | consuming payload (ECHO also drains its buffer here)
// ST_SEND    | ADD32 result, 4 bytes LSB first, rx stalled
module uart_alu_responder #(
  parameter logic [7:0] OP_ECHO  = 8'hEC,
  parameter logic [7:0] OP_ADD32 = 8'hAD
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_SEND
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [23:0] opnd_q, opnd_d;       // first three bytes of the operand being assembled
  logic [1:0]  opnd_idx_q, opnd_idx_d;
  logic [1:0]  send_idx_q, send_idx_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_full_q, buf_full_d;

  logic        is_echo, is_add;
  logic        rx_fire, tx_fire;
  logic [15:0] len_full;

  assign is_echo  = (op_q == OP_ECHO);
  assign is_add   = (op_q == OP_ADD32);
  assign len_full = {rx_data_i, len_lo_q};

  // Outputs are derived from flops only, except that rx_ready_o also depends
  // on tx_ready_i. That lets the ECHO buffer drain and refill in the same cycle.
  always_comb begin
    rx_ready_o = 1'b1;
    if (state_q == ST_SEND) begin
      rx_ready_o = 1'b0;
    end else if (state_q == ST_PAYLOAD) begin
      rx_ready_o = (cnt_q != 16'd0) && (!is_echo || !buf_full_q || tx_ready_i);
    end
  end

  always_comb begin
    tx_data_o = buf_q;
    if (state_q == ST_SEND) begin
      case (send_idx_q)
        2'd0:    tx_data_o = acc_q[7:0];
        2'd1:    tx_data_o = acc_q[15:8];
        2'd2:    tx_data_o = acc_q[23:16];
        default: tx_data_o = acc_q[31:24];
      endcase
    end
  end

  assign tx_valid_o = buf_full_q || (state_q == ST_SEND);
  assign busy_o     = (state_q != ST_OPCODE);
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign tx_fire    = tx_valid_o && tx_ready_i;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_lo_d   = len_lo_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    opnd_idx_d = opnd_idx_q;
    send_idx_d = send_idx_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    case (state_q)
      ST_OPCODE: begin
        if (rx_fire) begin
          op_d       = rx_data_i;
          acc_d      = 32'd0;
          opnd_idx_d = 2'd0;
          send_idx_d = 2'd0;
          state_d    = ST_RSVD;
        end
      end
      ST_RSVD: begin
        if (rx_fire) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (rx_fire) begin
          len_lo_d = rx_data_i;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_fire) begin
          if (len_full <= 16'd4) begin
            cnt_d   = 16'd0;
            state_d = is_add ? ST_SEND : ST_OPCODE;
          end else begin
            cnt_d   = len_full - 16'd4;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        buf_full_d = buf_full_q && !tx_ready_i;
        if (rx_fire) begin
          cnt_d = cnt_q - 16'd1;
          if (is_echo) begin
            buf_d      = rx_data_i;
            buf_full_d = 1'b1;
          end
          if (is_add) begin
            opnd_d     = {rx_data_i, opnd_q[23:8]};
            opnd_idx_d = opnd_idx_q + 2'd1;
            if (opnd_idx_q == 2'd3) acc_d = acc_q + {rx_data_i, opnd_q};
          end
        end
        // ECHO leaves only once the last buffered byte has been taken.
        if (cnt_d == 16'd0 && !buf_full_d) state_d = is_add ? ST_SEND : ST_OPCODE;
      end
      ST_SEND: begin
        if (tx_fire) begin
          send_idx_d = send_idx_q + 2'd1;
          if (send_idx_q == 2'd3) state_d = ST_OPCODE;
        end
      end
      default: state_d = ST_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_OPCODE;
      op_q       <= 8'h00;
      len_lo_q   <= 8'h00;
      cnt_q      <= 16'd0;
      acc_q      <= 32'd0;
      opnd_q     <= 24'd0;
      opnd_idx_q <= 2'd0;
      send_idx_q <= 2'd0;
      buf_q      <= 8'h00;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_lo_q   <= len_lo_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      opnd_idx_q <= opnd_idx_d;
      send_idx_q <= send_idx_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

endmodule
